// File: rtl/updown_mod_counter.sv
// WIDTH-bit modulo-MOD up/down counter with enable, clamped parallel load,
// wrap or saturate at the range ends, and a registered terminal-count pulse.
module updown_mod_counter #(
  parameter int     WIDTH = 4,
  parameter longint MOD   = 16,
  parameter int     SAT   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc
);

  if ((WIDTH < 1) || (WIDTH > 32)) begin : g_bad_width
    $fatal(1, "updown_mod_counter: WIDTH=%0d outside 1..32", WIDTH);
  end
  if ((MOD < 2) || (MOD > (longint'(1) << WIDTH))) begin : g_bad_mod
    $fatal(1, "updown_mod_counter: MOD=%0d outside 2..2**WIDTH", MOD);
  end

  localparam logic [WIDTH:0]   MODX = (WIDTH+1)'(MOD);
  localparam logic [WIDTH:0]   ONE  = (WIDTH+1)'(1);
  localparam logic [WIDTH-1:0] TOP  = WIDTH'(MOD - 1);

  // One extra bit: inc reaching MOD marks the top, dec's MSB is the borrow out of 0.
  logic [WIDTH:0] inc, dec;
  logic           at_top, at_bot;

  assign inc    = {1'b0, q} + ONE;
  assign dec    = {1'b0, q} - ONE;
  assign at_top = (inc == MODX);
  assign at_bot = dec[WIDTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q  <= '0;
      tc <= 1'b0;
    end else if (load) begin
      q  <= ({1'b0, load_val} >= MODX) ? TOP : load_val;
      tc <= 1'b0;
    end else if (en) begin
      if (up) begin
        if (at_top) begin
          q  <= (SAT != 0) ? TOP : '0;
          tc <= 1'b1;
        end else begin
          q  <= inc[WIDTH-1:0];
          tc <= 1'b0;
        end
      end else begin
        if (at_bot) begin
          q  <= (SAT != 0) ? '0 : TOP;
          tc <= 1'b1;
        end else begin
          q  <= dec[WIDTH-1:0];
          tc <= 1'b0;
        end
      end
    end else begin
      tc <= 1'b0;
    end
  end

endmodule
